// File: rtl/excite_ramp.sv
// excite_ramp: latches a requested pitch period / excitation amplitude,
// applies it at a pitch-period boundary (or the next sample tick while in
// noise mode), and ramps the amplitude toward the applied target by STEP per
// sample tick without overshoot.
// Optional feature macro: EXCITE_RAMP_TIMEOUT_EN adds a 10-bit PEND watchdog
// that forces the apply after 1023 clocks without an apply condition.
module excite_ramp #(
  parameter int unsigned STEP = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         tgt_period,
  input  logic signed [14:0] tgt_amp,
  input  logic               load,
  output logic               ready,
  input  logic               strobe,
  input  logic               period_done,
  output logic [7:0]         period,
  output logic signed [14:0] amplitude,
  output logic               settled
);

  localparam int unsigned PW  = 8;
  localparam int unsigned AW  = 15;
  localparam int unsigned RW  = 16;
  localparam int unsigned WDW = 10;

  localparam logic signed [RW-1:0] STEP_W = RW'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         period_q;
  logic [PW-1:0]         pend_period_q;
  logic signed [AW-1:0]  amp_q;
  logic signed [AW-1:0]  amp_d;
  logic signed [AW-1:0]  amp_tgt_q;
  logic signed [AW-1:0]  pend_amp_q;
  logic signed [AW-1:0]  load_amp_c;
  logic                  ready_q;
  logic                  settled_q;
  logic                  wd_hit_c;
  logic                  apply_c;

  logic signed [RW-1:0]  amp_w;
  logic signed [RW-1:0]  tgt_w;
  logic signed [RW-1:0]  up_w;
  logic signed [RW-1:0]  dn_w;
  logic signed [RW-1:0]  ramp_w;

`ifdef EXCITE_RAMP_TIMEOUT_EN
  logic [WDW-1:0] wd_q;

  // Watchdog: counts clocks spent in PEND; the edge that brings it to 1023 applies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (state_q == IDLE) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WDW'(1);
    end
  end

  assign wd_hit_c = (state_q == PEND) && (wd_q == WDW'(1022));
`else
  assign wd_hit_c = 1'b0;
`endif

  // Negative requests clamp to zero amplitude.
  assign load_amp_c = tgt_amp[AW-1] ? '0 : tgt_amp;

  // Apply at a period boundary, or on a sample tick while in noise mode (period 0).
  assign apply_c = (state_q == PEND) &&
                   (period_done || (strobe && (period_q == '0)) || wd_hit_c);

  // One ramp step toward the current target, clamped so it never crosses it.
  always_comb begin
    amp_w  = RW'(amp_q);
    tgt_w  = RW'(amp_tgt_q);
    up_w   = amp_w + STEP_W;
    dn_w   = amp_w - STEP_W;
    ramp_w = amp_w;
    if (amp_w < tgt_w) begin
      ramp_w = (up_w > tgt_w) ? tgt_w : up_w;
    end else if (amp_w > tgt_w) begin
      ramp_w = (dn_w < tgt_w) ? tgt_w : dn_w;
    end
    amp_d = strobe ? AW'(ramp_w) : amp_q;
  end

  // Request FSM, applied values, amplitude and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      period_q      <= '0;
      pend_period_q <= '0;
      amp_q         <= '0;
      amp_tgt_q     <= '0;
      pend_amp_q    <= '0;
      ready_q       <= 1'b1;
      settled_q     <= 1'b1;
    end else begin
      amp_q     <= amp_d;
      settled_q <= (state_q == IDLE) && (amp_q == amp_tgt_q);
      case (state_q)
        IDLE: begin
          if (load) begin
            pend_period_q <= tgt_period;
            pend_amp_q    <= load_amp_c;
            ready_q       <= 1'b0;
            state_q       <= PEND;
          end
        end
        PEND: begin
          if (apply_c) begin
            period_q  <= pend_period_q;
            amp_tgt_q <= pend_amp_q;
            ready_q   <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign period    = period_q;
  assign amplitude = amp_q;
  assign settled   = settled_q;

endmodule
